bch_enc_serial: RTL

- Serial systematic BCH encoder: one bit per clock in, one codeword bit per clock out.
- Data bits pass through with 1-cycle latency. The r = n-k_max parity bits follow immediately, MSB (highest degree) first.
- Sits at the transmit end of the link and produces the frames the BCH decoder chain consumes, using the same isop/ival/ieop framing.
- Shortened frames (k ≤ k_max data bits) are supported.

---
 rtl/bch_enc_serial.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bch_enc_serial.sv
// Serial systematic BCH encoder. Data bits pass through one cycle late, then the
// r parity bits held in the division LFSR are shifted out highest degree first.
module bch_enc_serial #(
  parameter int           m     = 4,
  parameter int           k_max = 5,
  parameter int           n     = 15,
  parameter int           r     = n - k_max,
  parameter logic [r:0]   pGEN  = 11'h537
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic isop,
  input  logic ival,
  input  logic ieop,
  input  logic idat,
  output logic ordy,
  output logic osop,
  output logic oval,
  output logic oeop,
  output logic odat,
  output logic oerr
);

  localparam int CW = ($clog2(k_max + 1) > m) ? $clog2(k_max + 1) : m;
  localparam int PW = $clog2(r + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(k_max + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(k_max);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t        state_q, state_d;
  logic [r-1:0]  lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] parCnt_q, parCnt_d;
  logic          osop_q, osop_d;
  logic          oval_q, oval_d;
  logic          oeop_q, oeop_d;
  logic          odat_q, odat_d;
  logic          oerr_q, oerr_d;

  logic          accept;
  logic          fb;
  logic [r-1:0]  lfsrBase;
  logic [r-1:0]  lfsrStep;
  logic [CW-1:0] cntInc;
  logic [CW-1:0] cntNew;

  assign ordy   = (state_q != PARITY);
  assign accept = ival & ordy;

  // A start-of-frame bit divides from a clean remainder, whatever the LFSR held.
  always_comb begin
    lfsrBase = isop ? '0 : lfsr_q;
    fb       = idat ^ lfsrBase[r-1];
    lfsrStep = {lfsrBase[r-2:0], 1'b0} ^ (fb ? pGEN[r-1:0] : '0);
    cntInc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    parCnt_d = parCnt_q;
    osop_d   = 1'b0;
    oval_d   = 1'b0;
    oeop_d   = 1'b0;
    odat_d   = 1'b0;
    oerr_d   = 1'b0;
    cntNew   = cnt_q;
    case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          if (isop || (state_q == DATA)) begin
            cntNew = isop ? CW'(1) : cntInc;
            cnt_d  = cntNew;
            lfsr_d = lfsrStep;
            oval_d = 1'b1;
            odat_d = idat;
            osop_d = isop;
            oerr_d = isop && (state_q == DATA);
            if (ieop) begin
              state_d  = PARITY;
              parCnt_d = PW'(r - 1);
              if (cntNew > CNT_MAX) oerr_d = 1'b1;
            end else begin
              state_d = DATA;
            end
          end else begin
            oerr_d = 1'b1;
          end
        end
      end
      PARITY: begin
        oval_d = 1'b1;
        odat_d = lfsr_q[r-1];
        lfsr_d = {lfsr_q[r-2:0], 1'b0};
        if (parCnt_q == '0) begin
          oeop_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          parCnt_d = parCnt_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      parCnt_q <= '0;
      osop_q   <= 1'b0;
      oval_q   <= 1'b0;
      oeop_q   <= 1'b0;
      odat_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else if (iclkena) begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      parCnt_q <= parCnt_d;
      osop_q   <= osop_d;
      oval_q   <= oval_d;
      oeop_q   <= oeop_d;
      odat_q   <= odat_d;
      oerr_q   <= oerr_d;
    end
  end

  assign osop = osop_q;
  assign oval = oval_q;
  assign oeop = oeop_q;
  assign odat = odat_q;
  assign oerr = oerr_q;

endmodule
